// File: rtl/bus_share_arbiter.sv
// Round-robin bus share: one requester owns the bus per burst, beats land in a
// single-entry output register tagged with the owner index.
//
// state  | meaning
// IDLE   | no owner; pick next valid requester starting at rr_ptr
// LOCKED | owner holds the bus until its last beat is accepted
module bus_share_arbiter #(
    parameter int BUS_SIZE  = 16,
    parameter int IDX_COUNT = 16,
    parameter int IDX_SIZE  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [IDX_COUNT-1:0]          req_valid,
    input  logic [IDX_COUNT-1:0]          req_last,
    input  logic [BUS_SIZE*IDX_COUNT-1:0] req_data,
    output logic [IDX_COUNT-1:0]          req_ready,
    output logic                          out_valid,
    output logic                          out_last,
    output logic [BUS_SIZE-1:0]           out_data,
    output logic [IDX_SIZE-1:0]           out_index,
    input  logic                          out_ready,
    output logic                          busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(IDX_COUNT - 1);

    state_t              state, state_nxt;
    logic [IDX_SIZE-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDX_SIZE-1:0] owner, owner_nxt;
    logic [IDX_SIZE-1:0] pick, cand;
    logic                pick_found;
    logic                owner_valid, owner_last, accept;
    logic [BUS_SIZE-1:0] owner_data;

    // Wraps at IDX_COUNT-1 explicitly so non-power-of-two counts behave.
    function automatic logic [IDX_SIZE-1:0] wrap_inc(input logic [IDX_SIZE-1:0] v);
        return (v == LAST_IDX) ? '0 : v + 1'b1;
    endfunction

    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = rr_ptr;
        for (int i = 0; i < IDX_COUNT; i++) begin
            if (!pick_found && req_valid[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
            cand = wrap_inc(cand);
        end
    end

    assign owner_valid = req_valid[owner];
    assign owner_last  = req_last[owner];
    assign owner_data  = req_data[owner*BUS_SIZE +: BUS_SIZE];
    assign accept      = (state == LOCKED) && owner_valid && (!out_valid || out_ready);

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    owner_nxt = pick;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                req_ready[owner] = !out_valid || out_ready;
                if (accept && owner_last) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = wrap_inc(owner);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            owner  <= owner_nxt;
        end
    end

    // An accept in the same cycle as a drain simply overwrites the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_last  <= owner_last;
            out_data  <= owner_data;
            out_index <= owner;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign busy = (state == LOCKED) || out_valid;

endmodule

// File: tb/tb_bus_share_arbiter.sv
// Bench for bus_share_arbiter: directed scenarios followed by randomized
// bursts checked against a transaction-level round-robin prediction.
module tb_bus_share_arbiter;

    localparam int W  = 16;
    localparam int N  = 16;
    localparam int IW = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [W*N-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_last;
    logic [W-1:0]    out_data;
    logic [IW-1:0]   out_index;
    logic            out_ready;
    logic            busy;

    int total = 0;
    int bad   = 0;

    // per-requester beat queues {last, data} and expected output {index, last, data}
    logic [16:0] rq [N][$];
    logic [16:0] mq [N][$];
    logic [20:0] exp_q [$];
    logic [20:0] exp_v;
    logic [16:0] beat;
    bit          started [N];
    int          order [5] = '{0, 5, 15, 0, 5};
    int          ptr, found, cyc, nb, len;

    bus_share_arbiter #(.BUS_SIZE(W), .IDX_COUNT(N), .IDX_SIZE(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_index (out_index),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic clr();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
    endtask

    task automatic set_req(input int i, input bit v, input bit l, input logic [15:0] d);
        req_valid[i]        = v;
        req_last[i]         = l;
        req_data[i*W +: W]  = d;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"},  out_last,  0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_out_index"}, out_index, 0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_busy"},      busy,      0);
    endtask

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        clr();
        repeat (3) nxt();
        #1 check_zero("rst");
        nxt();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("idle_valid", out_valid, 0);
            check("idle_ready", req_ready, 0);
            check("idle_busy", busy, 0);
            nxt();
        end

        // requester 3, four-beat burst
        set_req(3, 1, 0, 16'hA000);
        #1 check("t2_first_ready", req_ready, 0);
        nxt();
        for (int k = 0; k < 4; k++) begin
            set_req(3, 1, k == 3, 16'hA000 + 16'(k));
            #1 check("t2_ready", req_ready, 32'h8);
            if (k > 0) begin
                check("t2_out_valid", out_valid, 1);
                check("t2_out_data", out_data, 16'hA000 + 16'(k - 1));
                check("t2_out_index", out_index, 3);
                check("t2_out_last", out_last, 0);
            end
            nxt();
        end
        clr();
        #1;
        check("t2_tail_data", out_data, 16'hA003);
        check("t2_tail_last", out_last, 1);
        check("t2_tail_ready", req_ready, 0);
        check("t2_tail_busy", busy, 1);
        nxt();
        // rr_ptr=4: with 2 and 6 both requesting, 6 wins
        set_req(2, 1, 1, 16'h2222);
        set_req(6, 1, 1, 16'h6666);
        #1 check("t2_drained", out_valid, 0);
        nxt();
        #1 check("t2_rrptr_grant6", req_ready, 32'h40);
        nxt();
        set_req(6, 0, 0, 16'h0);
        #1 check("t2_idx6", out_index, 6);
        check("t2_gap", req_ready, 0);
        nxt();
        #1 check("t2_grant2", req_ready, 32'h4);
        nxt();
        clr();
        #1 check("t2_data2", out_data, 16'h2222);
        nxt();

        // requesters 0, 5, 15 hold single-beat bursts from reset
        rst_n = 1'b0;
        set_req(0, 1, 1, 16'h1000);
        set_req(5, 1, 1, 16'h1005);
        set_req(15, 1, 1, 16'h100F);
        #1 check("t3_rst_busy", busy, 0);
        nxt();
        nxt();
        rst_n = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1 check("t3_gap_ready", req_ready, 0);
            if (g > 0) begin
                check("t3_out_index", out_index, order[g-1]);
                check("t3_out_data", out_data, 16'h1000 + 16'(order[g-1]));
            end
            nxt();
            #1 check("t3_grant", req_ready, 32'(1) << order[g]);
            nxt();
        end
        clr();
        #1 check("t3_last_index", out_index, 5);
        nxt();

        // backpressure on requester 2
        set_req(2, 1, 0, 16'hB000);
        #1 check("t4_idle", req_ready, 0);
        nxt();
        #1 check("t4_grant", req_ready, 32'h4);
        nxt();
        out_ready = 1'b0;
        set_req(2, 1, 0, 16'hB001);
        for (int s = 0; s < 5; s++) begin
            #1;
            check("t4_stall_ready", req_ready, 0);
            check("t4_stall_data", out_data, 16'hB000);
            check("t4_stall_valid", out_valid, 1);
            nxt();
        end
        out_ready = 1'b1;
        #1 check("t4_resume_ready", req_ready, 32'h4);
        check("t4_resume_data", out_data, 16'hB000);
        nxt();
        set_req(2, 1, 1, 16'hB002);
        #1 check("t4_b1_ready", req_ready, 32'h4);
        check("t4_b1_data", out_data, 16'hB001);
        nxt();
        clr();
        #1 check("t4_b2_data", out_data, 16'hB002);
        check("t4_b2_last", out_last, 1);
        check("t4_b2_ready", req_ready, 0);
        nxt();
        #1 check("t4_empty", out_valid, 0);
        nxt();

        // lock hold: 7 pauses mid-burst while 8 waits
        set_req(7, 1, 0, 16'hC000);
        set_req(8, 1, 1, 16'hD000);
        #1 check("t5_idle", req_ready, 0);
        nxt();
        #1 check("t5_grant7", req_ready, 32'h80);
        nxt();
        set_req(7, 0, 0, 16'h0);
        for (int s = 0; s < 6; s++) begin
            #1 check("t5_hold_r8", req_ready[8], 0);
            check("t5_hold_busy", busy, 1);
            nxt();
        end
        set_req(7, 1, 1, 16'hC001);
        #1 check("t5_resume7", req_ready, 32'h80);
        nxt();
        set_req(7, 0, 0, 16'h0);
        #1 check("t5_gap", req_ready, 0);
        check("t5_c001", out_data, 16'hC001);
        nxt();
        #1 check("t5_grant8", req_ready, 32'h100);
        nxt();
        clr();
        #1 check("t5_idx8", out_index, 8);
        check("t5_d000", out_data, 16'hD000);
        nxt();

        // reset in the middle of a five-beat burst from 9
        set_req(9, 1, 0, 16'hE000);
        #1 check("t6_idle", req_ready, 0);
        nxt();
        #1 check("t6_grant9", req_ready, 32'h200);
        nxt();
        set_req(9, 1, 0, 16'hE001);
        #1 check("t6_beat2_ready", req_ready, 32'h200);
        rst_n = 1'b0;
        #1 check_zero("t6_async");
        nxt();
        set_req(1, 1, 1, 16'hF001);
        rst_n = 1'b1;
        #1 check("t6_post_idle", req_ready, 0);
        nxt();
        #1 check("t6_grant1", req_ready, 32'h2);
        nxt();
        clr();

        // randomized bursts; grant order predicted from the round-robin rule alone
        rst_n = 1'b0;
        nxt();
        nxt();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            started[i] = 0;
            if ($urandom_range(1) == 1) begin
                nb = $urandom_range(3, 1);
                for (int b = 0; b < nb; b++) begin
                    len = $urandom_range(4, 1);
                    for (int e = 0; e < len; e++)
                        rq[i].push_back({e == len - 1, 16'($urandom)});
                end
            end
        end
        rq[11].push_back({1'b1, 16'h5A5A});
        for (int i = 0; i < N; i++) mq[i] = rq[i];
        exp_q.delete();
        ptr = 0;
        for (int guard = 0; guard < 1000; guard++) begin
            found = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (ptr + k) % N;
                if (found < 0 && mq[c].size() > 0) found = c;
            end
            if (found < 0) break;
            do begin
                beat = mq[found].pop_front();
                exp_q.push_back({4'(found), beat});
            end while (!beat[16]);
            ptr = (found + 1) % N;
        end

        cyc = 0;
        while (exp_q.size() > 0 && cyc < 5000) begin
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() > 0 && !(started[i] && $urandom_range(3) == 0))
                    set_req(i, 1, rq[i][0][16], rq[i][0][15:0]);
                else
                    set_req(i, 0, 0, 16'($urandom));
            end
            out_ready = ($urandom_range(3) != 0);
            #1;
            check("rnd_ready_onehot", $countones(req_ready) <= 1, 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_beat", 1, 0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("rnd_data", out_data, exp_v[15:0]);
                    check("rnd_last", out_last, exp_v[16]);
                    check("rnd_index", out_index, exp_v[20:17]);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    beat = rq[i].pop_front();
                    started[i] = !beat[16];
                end
            end
            nxt();
            cyc++;
        end
        check("rnd_all_drained", exp_q.size(), 0);
        clr();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_share_arbiter.md
Name: bus_share_arbiter

Overview:
- Shares one BUS_SIZE-wide output bus between IDX_COUNT requesters.
- Each requester sends bursts of beats using a valid/ready/last handshake.
- Round-robin arbitration grants the bus to one requester, which keeps it until its last beat is accepted.
- The granted slice goes into a single-entry registered output stage. That stage feeds the downstream consumer and carries the owner index for routing on the far side.

Parameters:
BUS_SIZE, 16, width of one data beat
IDX_COUNT, 16, number of requesters; must satisfy IDX_COUNT <= 2**IDX_SIZE
IDX_SIZE, 4, width of owner index

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
req_valid  input  IDX_COUNT  bit i: requester i presents a beat
req_last  input  IDX_COUNT  bit i: the current beat of requester i ends its burst
req_data  input  BUS_SIZE*IDX_COUNT  requester i data at bits [i*BUS_SIZE +: BUS_SIZE]
req_ready  output  IDX_COUNT  bit i: beat from requester i accepted this cycle if valid
out_valid  output  1  output register holds a beat
out_last  output  1  held beat ends its burst
out_data  output  BUS_SIZE  held beat data
out_index  output  IDX_SIZE  owner index of held beat
out_ready  input  1  consumer accepts held beat
busy  output  1  state==LOCKED or out_valid

Behaviour:
- Reset (rst_n low, any time including mid-burst):
  - state=IDLE, rr_ptr=0, owner=0.
  - out_valid=0, out_last=0, out_data=0, out_index=0.
  - req_ready=0, busy=0.
  - An interrupted burst is dropped; no partial state survives.
- States IDLE and LOCKED:
  - IDLE: req_ready=0. If any req_valid bit is set, owner <= first set index scanning rr_ptr, rr_ptr+1, ... with wrap at IDX_COUNT-1 -> 0; state <= LOCKED. Otherwise stay in IDLE.
  - LOCKED: req_ready[owner] = !out_valid || out_ready. All other req_ready bits = 0 (combinational from registered state).
  - Beat accept: req_valid[owner] && req_ready[owner]. On accept: out_data <= owner slice, out_last <= req_last[owner], out_index <= owner, out_valid <= 1.
  - Accepted beat with req_last[owner]=1: state <= IDLE; rr_ptr <= owner+1, wrapping IDX_COUNT-1 -> 0, including when IDX_COUNT is not a power of two.
  - Owner deasserts req_valid mid-burst: the grant stays locked indefinitely. There is no timeout and no preemption.
- Output stage:
  - out_ready && out_valid && no accept this cycle -> out_valid <= 0.
  - Accept and drain in the same cycle -> the register is overwritten and out_valid stays 1.
  - out_data, out_last and out_index are stable while out_valid && !out_ready.
- Latency and throughput:
  - A request first seen in IDLE at cycle N is granted from cycle N+1. The first beat is accepted in N+1 and appears on out_valid in N+2.
  - Within a burst: 1 beat/cycle with out_ready held high.
  - Between bursts: exactly 1 IDLE cycle with no accept.
  - The output register may still hold the final beat while IDLE arbitrates.
- Fairness:
  - A requester that just finished has the lowest priority next.
  - Any continuously valid requester is granted within IDX_COUNT-1 bursts.
- Single-beat burst: valid with last=1 on the first beat -> one beat out, return to IDLE.
- req_valid/req_last/req_data of non-owners are ignored while LOCKED.

Test Plan:
- Reset then idle, all req_valid=0 for 10 cycles -> out_valid=0, req_ready=0, busy=0 throughout.
- Requester 3 sends 4 beats 0xA000..0xA003 (last on 4th), out_ready=1:
  - req_ready[3]=1 from cycle 1 after the first valid.
  - out_valid on 4 consecutive cycles with data 0xA000..0xA003, out_index=3, out_last only on 0xA003.
  - rr_ptr=4 afterwards.
- Requesters 0, 5, 15 hold single-beat bursts continuously from reset:
  - Grant order 0, 5, 15, 0, 5.
  - One idle cycle between grants.
  - Wrap from 15 back to 0 verified.
- Backpressure: requester 2 sends 3 beats with out_ready=0 for 5 cycles after the first beat:
  - out_data holds the first beat and req_ready[2]=0 during the stall.
  - On out_ready=1 the remaining beats follow 1/cycle with no loss or duplication.
- Lock hold: requester 7 sends 1 non-last beat, then drops valid for 6 cycles while requester 8 is valid:
  - req_ready[8]=0 throughout.
  - Requester 7 resumes with a last beat; requester 8 is granted after one IDLE cycle.
- Reset mid-burst: assert rst_n=0 during beat 2 of 5 from requester 9:
  - All outputs go to 0 immediately (asynchronous).
  - After release, requester 1 and requester 9 both valid -> requester 1 is granted first, since rr_ptr=0.
